// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data_ram port between the instruction refill path
// and the data cache path. One transaction at a time (I-read, D-read,
// D-write, or atomic D writeback-then-refill), round-robin on ties.
// All outputs are registered: they are decoded from the next state/owner so
// that their timing matches a decode of the current state register.
module mem_arbiter #(
    parameter int RAM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic        d_wb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wb_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        busy,
    output logic [1:0]  grant
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WB   = 3'd1,
        ST_RD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_WR   = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(RAM_LAT);

    // owner / last_grant encoding: 1'b0 = I side, 1'b1 = D side
    state_t      state_r, state_s;
    logic        owner_r, owner_s;
    logic        last_grant_r, last_grant_s;
    logic [2:0]  cnt_r, cnt_s;
    logic        pick_d_s;
    logic        cap_i_s, cap_d_s;

    logic        ram_en_s, ram_we_s, i_ack_s, d_ack_s, busy_s;
    logic [31:0] ram_addr_s, ram_wdata_s;
    logic [1:0]  grant_s;

    // State, owner, round-robin and latency counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b0;
            cnt_r        <= 3'd0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            last_grant_r <= last_grant_s;
            cnt_r        <= cnt_s;
        end
    end

    // Next-state logic: arbitration in IDLE, sequencing of the RAM access
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        last_grant_s = last_grant_r;
        cnt_s        = cnt_r;
        pick_d_s     = 1'b0;
        cap_i_s      = 1'b0;
        cap_d_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    // On a tie the side not granted last wins
                    if (i_req && d_req) begin
                        pick_d_s = (last_grant_r == 1'b0);
                    end else begin
                        pick_d_s = d_req;
                    end
                    owner_s      = pick_d_s;
                    last_grant_s = pick_d_s;
                    if (!pick_d_s) begin
                        state_s = ST_RD;
                    end else if (d_wr) begin
                        state_s = ST_WR;
                    end else if (d_wb) begin
                        state_s = ST_WB;
                    end else begin
                        state_s = ST_RD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WB:   state_s = ST_RD;
            ST_WR:   state_s = ST_RESP;
            ST_RD: begin
                cnt_s   = LAT_LOAD;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_s = cnt_r - 3'd1;
                if (cnt_r == 3'd1) begin
                    cap_i_s = !owner_r;
                    cap_d_s = owner_r;
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state and next owner
    always_comb begin
        ram_en_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_addr_s  = 32'd0;
        ram_wdata_s = 32'd0;
        case (state_s)
            ST_WB: begin
                ram_en_s    = 1'b1;
                ram_we_s    = 1'b1;
                ram_addr_s  = d_wb_addr;
                ram_wdata_s = d_wdata;
            end
            ST_WR: begin
                ram_en_s    = 1'b1;
                ram_we_s    = 1'b1;
                ram_addr_s  = d_addr;
                ram_wdata_s = d_wdata;
            end
            ST_RD: begin
                ram_en_s   = 1'b1;
                ram_addr_s = owner_s ? d_addr : i_addr;
            end
            default: begin
                ram_en_s = 1'b0;
            end
        endcase
        i_ack_s = (state_s == ST_RESP) && !owner_s;
        d_ack_s = (state_s == ST_RESP) && owner_s;
        busy_s  = (state_s != ST_IDLE);
        if (state_s == ST_IDLE) begin
            grant_s = 2'b00;
        end else begin
            grant_s = owner_s ? 2'b10 : 2'b01;
        end
    end

    // Registered RAM-side outputs, acks, busy and grant
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= 32'd0;
            ram_wdata <= 32'd0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            busy      <= 1'b0;
            grant     <= 2'b00;
        end else begin
            ram_en    <= ram_en_s;
            ram_we    <= ram_we_s;
            ram_addr  <= ram_addr_s;
            ram_wdata <= ram_wdata_s;
            i_ack     <= i_ack_s;
            d_ack     <= d_ack_s;
            busy      <= busy_s;
            grant     <= grant_s;
        end
    end

    // Read data capture; each side holds its value until its next read
    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata <= 32'd0;
            d_rdata <= 32'd0;
        end else begin
            if (cap_i_s) begin
                i_rdata <= ram_rdata;
            end
            if (cap_d_s) begin
                d_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: two instances (RAM_LAT=1 and RAM_LAT=3), each
// with a small behavioural RAM, and a scoreboard of expected completions.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Instance 1 (RAM_LAT = 1)
    logic        i_req1, d_req1, d_wr1, d_wb1;
    logic [31:0] i_addr1, d_addr1, d_wb_addr1, d_wdata1;
    logic        i_ack1, d_ack1, ram_en1, ram_we1, busy1;
    logic [31:0] i_rdata1, d_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
    logic [1:0]  grant1;

    // Instance 3 (RAM_LAT = 3)
    logic        i_req3, d_req3, d_wr3, d_wb3;
    logic [31:0] i_addr3, d_addr3, d_wb_addr3, d_wdata3;
    logic        i_ack3, d_ack3, ram_en3, ram_we3, busy3;
    logic [31:0] i_rdata3, d_rdata3, ram_addr3, ram_wdata3, ram_rdata3;
    logic [1:0]  grant3;

    mem_arbiter #(.RAM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req1), .i_addr(i_addr1), .i_ack(i_ack1), .i_rdata(i_rdata1),
        .d_req(d_req1), .d_wr(d_wr1), .d_wb(d_wb1), .d_addr(d_addr1),
        .d_wb_addr(d_wb_addr1), .d_wdata(d_wdata1), .d_ack(d_ack1), .d_rdata(d_rdata1),
        .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
        .ram_rdata(ram_rdata1), .busy(busy1), .grant(grant1)
    );

    mem_arbiter #(.RAM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .i_req(i_req3), .i_addr(i_addr3), .i_ack(i_ack3), .i_rdata(i_rdata3),
        .d_req(d_req3), .d_wr(d_wr3), .d_wb(d_wb3), .d_addr(d_addr3),
        .d_wb_addr(d_wb_addr3), .d_wdata(d_wdata3), .d_ack(d_ack3), .d_rdata(d_rdata3),
        .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
        .ram_rdata(ram_rdata3), .busy(busy3), .grant(grant3)
    );

    // RAM models: unwritten words read as a fixed function of the address
    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];
    bit          wr1  [0:1023];
    bit          wr3  [0:1023];
    logic        bd_we1 = 1'b0, bd_we3 = 1'b0;
    logic [31:0] bd_addr = 32'd0, bd_data = 32'd0;
    logic [31:0] pipe1;
    logic [31:0] pipe3 [0:2];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] rd1(input logic [31:0] a);
        return wr1[a[11:2]] ? mem1[a[11:2]] : dflt(a);
    endfunction

    function automatic logic [31:0] rd3(input logic [31:0] a);
        return wr3[a[11:2]] ? mem3[a[11:2]] : dflt(a);
    endfunction

    always @(posedge clk) begin
        if (bd_we1) begin
            mem1[bd_addr[11:2]] <= bd_data;
            wr1[bd_addr[11:2]]  <= 1'b1;
        end
        if (ram_en1 && ram_we1) begin
            mem1[ram_addr1[11:2]] <= ram_wdata1;
            wr1[ram_addr1[11:2]]  <= 1'b1;
        end
        pipe1 <= (ram_en1 && !ram_we1) ? rd1(ram_addr1) : 32'hFFFF_FFFF;
    end
    assign ram_rdata1 = pipe1;

    always @(posedge clk) begin
        if (bd_we3) begin
            mem3[bd_addr[11:2]] <= bd_data;
            wr3[bd_addr[11:2]]  <= 1'b1;
        end
        if (ram_en3 && ram_we3) begin
            mem3[ram_addr3[11:2]] <= ram_wdata3;
            wr3[ram_addr3[11:2]]  <= 1'b1;
        end
        pipe3[0] <= (ram_en3 && !ram_we3) ? rd3(ram_addr3) : 32'hFFFF_FFFF;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign ram_rdata3 = pipe3[2];

    // Scoreboard and RAM access log
    typedef struct { bit is_d; logic [31:0] rdata; } exp_t;
    typedef struct { int cyc; bit we; logic [31:0] addr; logic [31:0] wdata; } acc_t;
    exp_t        sb[$];
    acc_t        lg[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_d = 32'd0;
    logic [1:0]  g_first;

    task automatic preload(input bit which, input logic [31:0] a, input logic [31:0] d);
        bd_addr = a;
        bd_data = d;
        if (which) bd_we3 = 1'b1; else bd_we1 = 1'b1;
        @(posedge clk); #1;
        bd_we1 = 1'b0;
        bd_we3 = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // Wait for the next ack on instance 1, logging RAM accesses; the
    // cycle count is relative to the cycle in which the task was entered
    task automatic run1(output bit side, output int cyc);
        exp_t e;
        bit   done;
        bit   seen;
        logic [31:0] got;
        done = 1'b0; seen = 1'b0; cyc = 0; side = 1'b0;
        g_first = 2'b00;
        lg.delete();
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (busy1 && !seen) begin
                seen = 1'b1;
                g_first = grant1;
            end
            if (ram_en1) lg.push_back('{cyc, ram_we1, ram_addr1, ram_wdata1});
            if (i_ack1 || d_ack1) begin
                done = 1'b1;
                side = d_ack1;
                n_cmp++;
                if ((i_ack1 && d_ack1) !== 1'b0) begin
                    n_err++;
                    $display("FAIL both_acks: i_ack=%b d_ack=%b, required only one", i_ack1, d_ack1);
                end
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_empty: ack on side %0d with nothing expected", side);
                end else begin
                    e = sb.pop_front();
                    if (side !== e.is_d) begin
                        n_err++;
                        $display("FAIL ack_side: got side %0d, required %0d", side, e.is_d);
                    end
                    got = side ? d_rdata1 : i_rdata1;
                    n_cmp++;
                    if (got !== e.rdata) begin
                        n_err++;
                        $display("FAIL rdata: got %h, required %h", got, e.rdata);
                    end
                end
                if (side) d_req1 = 1'b0; else i_req1 = 1'b0;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL ack_timeout: no ack within 40 cycles");
            cyc = -1;
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    task automatic chk_acc(input string nm, input int idx, input int c, input bit we,
                           input logic [31:0] a, input logic [31:0] wd);
        n_cmp++;
        if (lg.size() <= idx) begin
            n_err++;
            $display("FAIL %s: access %0d missing", nm, idx);
        end else if (lg[idx].cyc !== c || lg[idx].we !== we || lg[idx].addr !== a ||
                     (we && lg[idx].wdata !== wd)) begin
            n_err++;
            $display("FAIL %s: got cyc=%0d we=%b addr=%h wdata=%h, required cyc=%0d we=%b addr=%h wdata=%h",
                     nm, lg[idx].cyc, lg[idx].we, lg[idx].addr, lg[idx].wdata, c, we, a, wd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req1 = 1'b0; d_req1 = 1'b0; d_wr1 = 1'b0; d_wb1 = 1'b0;
        i_addr1 = 32'd0; d_addr1 = 32'd0; d_wb_addr1 = 32'd0; d_wdata1 = 32'd0;
        i_req3 = 1'b0; d_req3 = 1'b0; d_wr3 = 1'b0; d_wb3 = 1'b0;
        i_addr3 = 32'd0; d_addr3 = 32'd0; d_wb_addr3 = 32'd0; d_wdata3 = 32'd0;
        repeat (2) next_cycle();
        n_cmp++;
        if ({i_ack1, d_ack1, i_rdata1, d_rdata1, ram_en1, ram_we1, ram_addr1,
             ram_wdata1, busy1, grant1} !== 135'd0) begin
            n_err++;
            $display("FAIL reset1: ack=%b%b ird=%h drd=%h en=%b we=%b addr=%h wd=%h busy=%b grant=%b, required all 0",
                     i_ack1, d_ack1, i_rdata1, d_rdata1, ram_en1, ram_we1, ram_addr1, ram_wdata1, busy1, grant1);
        end
        n_cmp++;
        if ({i_ack3, d_ack3, ram_en3, busy3, grant3} !== 6'd0) begin
            n_err++;
            $display("FAIL reset3: got %b, required 000000", {i_ack3, d_ack3, ram_en3, busy3, grant3});
        end
        rst = 1'b0;
    endtask

    // Tie right after reset goes to D; a D re-request tying with pending I goes to I
    task automatic test_arb_after_reset();
        bit side; int cyc;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        exp_d = 32'd0;
        i_req1 = 1'b1; i_addr1 = 32'h300;
        d_req1 = 1'b1; d_addr1 = 32'h304; d_wr1 = 1'b0; d_wb1 = 1'b0;
        sb.push_back('{1'b1, dflt(32'h304)});
        sb.push_back('{1'b0, dflt(32'h300)});
        run1(side, cyc);
        chk_int("tie1_latency", cyc, 3);
        chk_int("tie1_grant", int'(g_first), 2);
        exp_d = dflt(32'h304);
        d_req1 = 1'b1; d_addr1 = 32'h308;
        sb.push_back('{1'b1, dflt(32'h308)});
        run1(side, cyc);
        chk_int("tie2_latency", cyc, 4);
        chk_int("tie2_grant", int'(g_first), 1);
        run1(side, cyc);
        chk_int("tie2_d_latency", cyc, 4);
        chk_int("tie2_d_grant", int'(g_first), 2);
        exp_d = dflt(32'h308);
    endtask

    task automatic test_i_read();
        bit side; int cyc;
        preload(1'b0, 32'h40, 32'h1234_5678);
        i_req1 = 1'b1; i_addr1 = 32'h40;
        sb.push_back('{1'b0, 32'h1234_5678});
        run1(side, cyc);
        chk_int("iread_latency", cyc, 3);
        chk_int("iread_accesses", lg.size(), 1);
        chk_acc("iread_access", 0, 1, 1'b0, 32'h40, 32'd0);
    endtask

    task automatic test_d_write();
        bit side; int cyc;
        next_cycle();
        d_req1 = 1'b1; d_wr1 = 1'b1; d_wb1 = 1'b0; d_addr1 = 32'h80; d_wdata1 = 32'hDEAD_BEEF;
        sb.push_back('{1'b1, exp_d});
        run1(side, cyc);
        chk_int("dwrite_latency", cyc, 2);
        chk_int("dwrite_accesses", lg.size(), 1);
        chk_acc("dwrite_access", 0, 1, 1'b1, 32'h80, 32'hDEAD_BEEF);
        next_cycle();
        d_req1 = 1'b1; d_wr1 = 1'b0; d_addr1 = 32'h80;
        sb.push_back('{1'b1, 32'hDEAD_BEEF});
        run1(side, cyc);
        chk_int("dread_latency", cyc, 3);
        exp_d = 32'hDEAD_BEEF;
    endtask

    task automatic test_wb_refill();
        bit side; int cyc;
        preload(1'b0, 32'h200, 32'h0BAD_F00D);
        d_req1 = 1'b1; d_wr1 = 1'b0; d_wb1 = 1'b1;
        d_wb_addr1 = 32'h100; d_wdata1 = 32'hAAAA_5555; d_addr1 = 32'h200;
        sb.push_back('{1'b1, 32'h0BAD_F00D});
        run1(side, cyc);
        d_wb1 = 1'b0;
        chk_int("wb_latency", cyc, 4);
        chk_int("wb_accesses", lg.size(), 2);
        chk_acc("wb_write", 0, 1, 1'b1, 32'h100, 32'hAAAA_5555);
        chk_acc("wb_refill", 1, 2, 1'b0, 32'h200, 32'd0);
        exp_d = 32'h0BAD_F00D;
    endtask

    task automatic test_lat3();
        preload(1'b1, 32'h44, 32'hCAFE_0044);
        i_req3 = 1'b1; i_addr3 = 32'h44;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            n_cmp++;
            if ({ram_en3, busy3, i_ack3, d_ack3} !== {(c == 1), (c <= 5), (c == 5), 1'b0}) begin
                n_err++;
                $display("FAIL lat3_cycle%0d: en/busy/iack/dack=%b, required %b", c,
                         {ram_en3, busy3, i_ack3, d_ack3}, {(c == 1), (c <= 5), (c == 5), 1'b0});
            end
            if (c == 1) begin
                n_cmp++;
                if (ram_addr3 !== 32'h44) begin
                    n_err++;
                    $display("FAIL lat3_addr: got %h, required 00000044", ram_addr3);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if (i_rdata3 !== 32'hCAFE_0044) begin
                    n_err++;
                    $display("FAIL lat3_rdata: got %h, required cafe0044", i_rdata3);
                end
                i_req3 = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        bit side; int cyc;
        next_cycle();
        d_req1 = 1'b1; d_wr1 = 1'b0; d_wb1 = 1'b0; d_addr1 = 32'h500;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        n_cmp++;
        if ({d_ack1, busy1, ram_en1, d_rdata1} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_mid: dack=%b busy=%b en=%b drdata=%h, required all 0",
                     d_ack1, busy1, ram_en1, d_rdata1);
        end
        rst = 1'b0;
        sb.push_back('{1'b1, dflt(32'h500)});
        run1(side, cyc);
        chk_int("reissue_latency", cyc, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_arb_after_reset();
        test_i_read();
        test_d_write();
        test_wb_refill();
        test_lat3();
        test_reset_mid();
        chk_int("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
